muller_c_proj_formal: RTL and testbench

MULLER_C_PROJ_FORMAL -- requirements
Module: muller_c_proj_formal

---
 rtl/muller_c_pkg.sv | 22 ++
 rtl/muller_c_proj_formal_if.sv | 28 ++
 rtl/muller_c_element.sv | 31 +++
 rtl/muller_c_proj_formal.sv | 134 +++++++++++++
 tb/tb_muller_c_proj_formal.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muller_c_pkg.sv
// Shared types and constants for the Muller C-element block:
// mode encoding, io_in bit positions and counter width.
package muller_c_pkg;

  localparam int IO_W  = 6;
  localparam int CNT_W = 8;

  localparam int A_BIT    = 0;
  localparam int B_BIT    = 1;
  localparam int C_BIT    = 2;
  localparam int EN_BIT   = 3;
  localparam int MODE_LSB = 4;
  localparam int MODE_MSB = 5;

  typedef enum logic [1:0] {
    MODE_C2   = 2'b00,
    MODE_C3   = 2'b01,
    MODE_ASYM = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

endpackage

// File: rtl/muller_c_proj_formal_if.sv
// Signal bundle for the C-element block: io_in from the master,
// c_out/c_out_n/agree/toggle_cnt returned by the slave.
interface muller_c_proj_formal_if;
  import muller_c_pkg::*;

  logic [IO_W-1:0]  io_in;
  logic             c_out;
  logic             c_out_n;
  logic             agree;
  logic [CNT_W-1:0] toggle_cnt;

  modport master (
    output io_in,
    input  c_out,
    input  c_out_n,
    input  agree,
    input  toggle_cnt
  );

  modport slave (
    input  io_in,
    output c_out,
    output c_out_n,
    output agree,
    output toggle_cnt
  );

endinterface

// File: rtl/muller_c_element.sv
// C-element state register: set_i forces 1, clr_i forces 0, else hold.
// Ports: clk, rst_n (async active-low), set_i, clr_i, state_o.
module muller_c_element (
  input  logic clk,
  input  logic rst_n,
  input  logic set_i,
  input  logic clr_i,
  output logic state_o
);

  logic state_d;
  logic state_q;

  always_comb begin
    state_d = state_q;
    if (set_i)
      state_d = 1'b1;
    else if (clr_i)
      state_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= 1'b0;
    else
      state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/muller_c_proj_formal.sv
// Mode-configurable Muller C-element with agree flag and toggle counter.
// Ports: clk, rst_n, io_in{mode,en,c,b,a}, c_out, c_out_n, agree,
// toggle_cnt. Define MULLER_C_PROPS_EN to compile in properties.
module muller_c_proj_formal
  import muller_c_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IO_W-1:0]  io_in,
  output logic             c_out,
  output logic             c_out_n,
  output logic             agree,
  output logic [CNT_W-1:0] toggle_cnt
);

  logic  a, b, c, en;
  mode_e mode;
  logic  set_raw, clr_raw;
  logic  set_en, clr_en;
  logic  agree_c;
  logic  toggle;

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    a    = io_in[A_BIT];
    b    = io_in[B_BIT];
    c    = io_in[C_BIT];
    en   = io_in[EN_BIT];
    mode = mode_e'(io_in[MODE_MSB:MODE_LSB]);
  end

  always_comb begin
    set_raw = 1'b0;
    clr_raw = 1'b0;
    agree_c = 1'b0;
    unique case (mode)
      MODE_C2: begin
        set_raw = a & b;
        clr_raw = ~a & ~b;
        agree_c = (a == c_out) && (b == c_out);
      end
      MODE_C3: begin
        set_raw = a & b & c;
        clr_raw = ~a & ~b & ~c;
        agree_c = (a == c_out) && (b == c_out)
               && (c == c_out);
      end
      MODE_ASYM: begin
        // c only gates the rising side
        set_raw = a & b & c;
        clr_raw = ~a & ~b;
        agree_c = (a == c_out) && (b == c_out);
      end
      MODE_HOLD: begin
        set_raw = 1'b0;
        clr_raw = 1'b0;
        agree_c = 1'b0;
      end
      default: begin
        set_raw = 1'b0;
        clr_raw = 1'b0;
        agree_c = 1'b0;
      end
    endcase
  end

  assign set_en = en & set_raw;
  assign clr_en = en & clr_raw;

  // set/clr are mutually exclusive, so a change occurs
  // only when the active one opposes the current state
  assign toggle = (set_en & ~c_out) | (clr_en & c_out);

  muller_c_element c_element (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_i   (set_en),
    .clr_i   (clr_en),
    .state_o (c_out)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (toggle)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign c_out_n    = ~c_out;
  assign agree      = agree_c;
  assign toggle_cnt = cnt_q;

`ifdef MULLER_C_PROPS_EN
  a_inv: assert property (
    @(posedge clk) c_out_n == ~c_out);

  a_hold: assert property (
    @(posedge clk) disable iff (!rst_n)
    (!en || mode == MODE_HOLD) |=> $stable(c_out));

  a_rise: assert property (
    @(posedge clk) disable iff (!rst_n)
    $rose(c_out) |-> $past(set_raw));

  a_cnt: assert property (
    @(posedge clk) disable iff (!rst_n)
    $changed(toggle_cnt) == $changed(c_out));

  c_c2: cover property (
    @(posedge clk) disable iff (!rst_n)
    (mode == MODE_C2 && c_out)
    ##[1:$] (mode == MODE_C2 && !c_out));

  c_c3: cover property (
    @(posedge clk) disable iff (!rst_n)
    (mode == MODE_C3 && c_out)
    ##[1:$] (mode == MODE_C3 && !c_out));

  c_asym: cover property (
    @(posedge clk) disable iff (!rst_n)
    (mode == MODE_ASYM && c_out)
    ##[1:$] (mode == MODE_ASYM && !c_out));
`else
`endif

endmodule

// File: tb/tb_muller_c_proj_formal.sv
// Directed self-checking bench for muller_c_proj_formal.
// Inputs change 1ns after a rising edge; outputs checked there too.
module tb_muller_c_proj_formal;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  muller_c_proj_formal_if bus ();

  muller_c_proj_formal dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io_in      (bus.io_in),
    .c_out      (bus.c_out),
    .c_out_n    (bus.c_out_n),
    .agree      (bus.agree),
    .toggle_cnt (bus.toggle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.io_in = 6'b000000;
    #1;
    cyc(1);
    #2;
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.io_in = 6'b000000;
    #2;
    checks++;
    if (bus.c_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_c_out got %b exp 0", bus.c_out);
    end
    checks++;
    if (bus.c_out_n !== 1'b1) begin
      errors++;
      $display("FAIL rst_c_out_n got %b exp 1", bus.c_out_n);
    end
    checks++;
    if (bus.toggle_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_cnt got %0d exp 0", bus.toggle_cnt);
    end
    #10;
    rst_n = 1'b1;
    bus.io_in = 6'b001000;
    cyc(4);
    checks++;
    if ({bus.c_out, bus.agree} !== 2'b01
        || bus.toggle_cnt !== 8'd0) begin
      errors++;
      $display("FAIL idle got c=%b ag=%b cnt=%0d exp c=0 ag=1 cnt=0",
               bus.c_out, bus.agree, bus.toggle_cnt);
    end
  endtask

  task automatic test_c2();
    bus.io_in = 6'b001001;
    cyc(1);
    checks++;
    if ({bus.c_out, bus.agree} !== 2'b00) begin
      errors++;
      $display("FAIL c2_a_only got c=%b ag=%b exp c=0 ag=0",
               bus.c_out, bus.agree);
    end
    bus.io_in = 6'b001011;
    #1;
    checks++;
    if (bus.c_out !== 1'b0) begin
      errors++;
      $display("FAIL c2_latency got %b exp 0", bus.c_out);
    end
    cyc(1);
    checks++;
    if ({bus.c_out, bus.c_out_n} !== 2'b10
        || bus.toggle_cnt !== 8'd1) begin
      errors++;
      $display("FAIL c2_set got c=%b cn=%b cnt=%0d exp c=1 cn=0 cnt=1",
               bus.c_out, bus.c_out_n, bus.toggle_cnt);
    end
    bus.io_in = 6'b001010;
    cyc(1);
    checks++;
    if ({bus.c_out, bus.agree} !== 2'b10
        || bus.toggle_cnt !== 8'd1) begin
      errors++;
      $display("FAIL c2_hold got c=%b ag=%b cnt=%0d exp c=1 ag=0 cnt=1",
               bus.c_out, bus.agree, bus.toggle_cnt);
    end
  endtask

  task automatic test_c3();
    do_reset();
    bus.io_in = 6'b011011;
    cyc(1);
    checks++;
    if (bus.c_out !== 1'b0) begin
      errors++;
      $display("FAIL c3_no_c got %b exp 0", bus.c_out);
    end
    bus.io_in = 6'b011111;
    cyc(1);
    checks++;
    if (bus.c_out !== 1'b1 || bus.toggle_cnt !== 8'd1) begin
      errors++;
      $display("FAIL c3_set got c=%b cnt=%0d exp c=1 cnt=1",
               bus.c_out, bus.toggle_cnt);
    end
    bus.io_in = 6'b011100;
    cyc(1);
    checks++;
    if ({bus.c_out, bus.agree} !== 2'b10) begin
      errors++;
      $display("FAIL c3_hold got c=%b ag=%b exp c=1 ag=0",
               bus.c_out, bus.agree);
    end
    bus.io_in = 6'b011000;
    cyc(1);
    checks++;
    if ({bus.c_out, bus.agree} !== 2'b01
        || bus.toggle_cnt !== 8'd2) begin
      errors++;
      $display("FAIL c3_clr got c=%b ag=%b cnt=%0d exp c=0 ag=1 cnt=2",
               bus.c_out, bus.agree, bus.toggle_cnt);
    end
  endtask

  task automatic test_asym();
    bus.io_in = 6'b101011;
    cyc(1);
    checks++;
    if (bus.c_out !== 1'b0) begin
      errors++;
      $display("FAIL asym_no_c got %b exp 0", bus.c_out);
    end
    bus.io_in = 6'b101111;
    cyc(1);
    checks++;
    if (bus.c_out !== 1'b1 || bus.toggle_cnt !== 8'd3) begin
      errors++;
      $display("FAIL asym_set got c=%b cnt=%0d exp c=1 cnt=3",
               bus.c_out, bus.toggle_cnt);
    end
    bus.io_in = 6'b101100;
    cyc(1);
    checks++;
    if ({bus.c_out, bus.agree} !== 2'b01
        || bus.toggle_cnt !== 8'd4) begin
      errors++;
      $display("FAIL asym_clr got c=%b ag=%b cnt=%0d exp c=0 ag=1 cnt=4",
               bus.c_out, bus.agree, bus.toggle_cnt);
    end
  endtask

  task automatic test_hold();
    logic [5:0] pat [10];
    pat = '{6'b000111, 6'b010000, 6'b100111, 6'b110000,
            6'b000011, 6'b010111, 6'b100000, 6'b110111,
            6'b000000, 6'b010111};
    bus.io_in = 6'b001011;
    cyc(1);
    checks++;
    if (bus.c_out !== 1'b1 || bus.toggle_cnt !== 8'd5) begin
      errors++;
      $display("FAIL hold_pre got c=%b cnt=%0d exp c=1 cnt=5",
               bus.c_out, bus.toggle_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      bus.io_in = pat[i];
      cyc(1);
      checks++;
      if (bus.c_out !== 1'b1 || bus.toggle_cnt !== 8'd5) begin
        errors++;
        $display("FAIL en0_hold[%0d] got c=%b cnt=%0d exp c=1 cnt=5",
                 i, bus.c_out, bus.toggle_cnt);
      end
    end
    for (int i = 0; i < 10; i++) begin
      bus.io_in = {2'b11, 1'b1, pat[i][2:0]};
      cyc(1);
      checks++;
      if ({bus.c_out, bus.agree} !== 2'b10
          || bus.toggle_cnt !== 8'd5) begin
        errors++;
        $display("FAIL m11_hold[%0d] got c=%b ag=%b cnt=%0d exp c=1 ag=0 cnt=5",
                 i, bus.c_out, bus.agree, bus.toggle_cnt);
      end
    end
  endtask

  task automatic test_mode_switch();
    bus.io_in = 6'b111000;
    cyc(1);
    bus.io_in = 6'b011000;
    cyc(1);
    checks++;
    if (bus.c_out !== 1'b0 || bus.toggle_cnt !== 8'd6) begin
      errors++;
      $display("FAIL mode_sw got c=%b cnt=%0d exp c=0 cnt=6",
               bus.c_out, bus.toggle_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      bus.io_in = (i % 2 == 0) ? 6'b001011 : 6'b001000;
      cyc(1);
      if (i == 254) begin
        checks++;
        if (bus.toggle_cnt !== 8'd255) begin
          errors++;
          $display("FAIL wrap_255 got %0d exp 255", bus.toggle_cnt);
        end
      end
    end
    checks++;
    if (bus.c_out !== 1'b0 || bus.toggle_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wrap_0 got c=%b cnt=%0d exp c=0 cnt=0",
               bus.c_out, bus.toggle_cnt);
    end
  endtask

  task automatic test_async_reset();
    bus.io_in = 6'b001011;
    cyc(1);
    checks++;
    if (bus.c_out !== 1'b1 || bus.toggle_cnt !== 8'd1) begin
      errors++;
      $display("FAIL ar_pre got c=%b cnt=%0d exp c=1 cnt=1",
               bus.c_out, bus.toggle_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.c_out, bus.c_out_n} !== 2'b01
        || bus.toggle_cnt !== 8'd0) begin
      errors++;
      $display("FAIL ar_async got c=%b cn=%b cnt=%0d exp c=0 cn=1 cnt=0",
               bus.c_out, bus.c_out_n, bus.toggle_cnt);
    end
    cyc(1);
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.c_out !== 1'b0) begin
      errors++;
      $display("FAIL ar_release got %b exp 0", bus.c_out);
    end
    cyc(1);
    checks++;
    if (bus.c_out !== 1'b1 || bus.toggle_cnt !== 8'd1) begin
      errors++;
      $display("FAIL ar_resume got c=%b cnt=%0d exp c=1 cnt=1",
               bus.c_out, bus.toggle_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_c2();
    test_c3();
    test_asym();
    test_hold();
    test_mode_switch();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
